// File: rtl/board_state_pkg.sv
// Shared definitions for the minesweeper board-state engine.
package board_state_pkg;

  localparam int unsigned BOARD_W     = 8;
  localparam int unsigned BOARD_TILES = 64;
  localparam int unsigned COORD_W     = $clog2(BOARD_W);
  localparam int unsigned TILE_W      = $clog2(BOARD_TILES);

  // Bit positions inside the registered button vector
  localparam int unsigned BTN_STEP  = 5;
  localparam int unsigned BTN_FLAG  = 4;
  localparam int unsigned BTN_UP    = 3;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_RIGHT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLACE,
    ST_PLAY,
    ST_WON,
    ST_LOST
  } state_e;

  typedef logic [BOARD_TILES-1:0] board_map_t;

endpackage

// File: rtl/board_state_mine_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used for mine placement.
// A zero seed is replaced by SEED_DEFAULT so the register never locks up.
module mine_lfsr #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;
  logic        fb;

  // Load has priority over advance; shift left with feedback into bit 0
  always_comb begin
    fb  = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];
    q_d = q_q;
    if (load) begin
      q_d = (seed == '0) ? SEED_DEFAULT : seed;
    end else if (adv) begin
      q_d = {q_q[14:0], fb};
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_q <= SEED_DEFAULT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/board_state.sv
// Minesweeper game-state engine: mine placement, cursor, flag/step actions,
// win/loss detection and the four maps consumed by the renderer.
module board_state
  import board_state_pkg::*;
#(
  parameter int unsigned NUM_MINES    = 10,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [15:0]            seed,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_flag,
  input  logic                   btn_step,
  output logic [BOARD_TILES-1:0] mineMap,
  output logic [BOARD_TILES-1:0] flagMap,
  output logic [BOARD_TILES-1:0] stepMap,
  output logic [BOARD_TILES-1:0] posMap,
  output logic                   busy,
  output logic                   game_won,
  output logic                   game_lost
);

  state_e             state_q, state_d;
  logic               start_q;
  logic [5:0]         btn_q;
  logic [5:0]         btn_now, btn_rise;
  logic               start_rise, new_game;
  board_map_t         mine_q, mine_d;
  board_map_t         flag_q, flag_d;
  board_map_t         step_q, step_d;
  board_map_t         pos_q, pos_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [TILE_W-1:0]  placed_q, placed_d;
  logic [TILE_W-1:0]  cand, cur;
  logic [15:0]        lfsr_q;
  logic               lfsr_load, lfsr_adv;
  logic               unused_lfsr;

  assign btn_now    = {btn_step, btn_flag, btn_up, btn_down, btn_left, btn_right};
  assign btn_rise   = btn_now & ~btn_q;
  assign start_rise = start & ~start_q;
  assign new_game   = start_rise && (state_q != ST_PLACE);
  assign cand       = lfsr_q[TILE_W-1:0];
  assign cur        = {row_q, col_q};
  assign lfsr_load  = new_game;
  assign lfsr_adv   = (state_q == ST_PLACE);
  assign unused_lfsr = ^lfsr_q[15:TILE_W];

  mine_lfsr #(
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_lfsr (
    .clk   (clk),
    .resetn(resetn),
    .load  (lfsr_load),
    .seed  (seed),
    .adv   (lfsr_adv),
    .q     (lfsr_q)
  );

  // Next-state, map and cursor updates; a new game overrides everything else
  always_comb begin
    state_d  = state_q;
    mine_d   = mine_q;
    flag_d   = flag_q;
    step_d   = step_q;
    row_d    = row_q;
    col_d    = col_q;
    placed_d = placed_q;

    case (state_q)
      ST_PLACE: begin
        if (placed_q == TILE_W'(NUM_MINES)) begin
          state_d = ST_PLAY;
        end else if (!mine_q[cand] && (cand != '0)) begin
          // Tile 0 is the first cursor tile and must stay safe
          mine_d[cand] = 1'b1;
          placed_d     = placed_q + TILE_W'(1);
        end
      end
      ST_PLAY: begin
        if (btn_rise[BTN_STEP]) begin
          if (!flag_q[cur] && !step_q[cur]) begin
            step_d[cur] = 1'b1;
            if (mine_q[cur]) begin
              step_d  = step_q | mine_q;
              state_d = ST_LOST;
            end
          end
        end else if (btn_rise[BTN_FLAG]) begin
          if (!step_q[cur]) flag_d[cur] = ~flag_q[cur];
        end else if (btn_rise[BTN_UP]) begin
          if (row_q != '0) row_d = row_q - COORD_W'(1);
        end else if (btn_rise[BTN_DOWN]) begin
          if (row_q != COORD_W'(BOARD_W - 1)) row_d = row_q + COORD_W'(1);
        end else if (btn_rise[BTN_LEFT]) begin
          if (col_q != '0) col_d = col_q - COORD_W'(1);
        end else if (btn_rise[BTN_RIGHT]) begin
          if (col_q != COORD_W'(BOARD_W - 1)) col_d = col_q + COORD_W'(1);
        end
        // Win uses the registered maps, so it lands the cycle after the last step
        if ((state_d == ST_PLAY) && (&(step_q | mine_q))) begin
          state_d = ST_WON;
        end
      end
      ST_IDLE, ST_WON, ST_LOST: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (new_game) begin
      state_d  = ST_PLACE;
      mine_d   = '0;
      flag_d   = '0;
      step_d   = '0;
      row_d    = '0;
      col_d    = '0;
      placed_d = '0;
    end
  end

  // One-hot cursor map follows the next cursor coordinates
  always_comb begin
    pos_d = board_map_t'(1) << {row_d, col_d};
  end

  // State, map and edge-detect registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      btn_q    <= '0;
      mine_q   <= '0;
      flag_q   <= '0;
      step_q   <= '0;
      pos_q    <= board_map_t'(1);
      row_q    <= '0;
      col_q    <= '0;
      placed_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      btn_q    <= btn_now;
      mine_q   <= mine_d;
      flag_q   <= flag_d;
      step_q   <= step_d;
      pos_q    <= pos_d;
      row_q    <= row_d;
      col_q    <= col_d;
      placed_q <= placed_d;
    end
  end

  assign mineMap   = mine_q;
  assign flagMap   = flag_q;
  assign stepMap   = step_q;
  assign posMap    = pos_q;
  assign busy      = (state_q == ST_PLACE);
  assign game_won  = (state_q == ST_WON);
  assign game_lost = (state_q == ST_LOST);

endmodule

// File: tb/tb_board_state.sv
// Self-checking bench for board_state: game-level model plus directed scenarios.
module tb_board_state;

  localparam int unsigned NM = 10;

  localparam bit [6:0] B_START = 7'h40;
  localparam bit [6:0] B_UP    = 7'h20;
  localparam bit [6:0] B_DOWN  = 7'h10;
  localparam bit [6:0] B_LEFT  = 7'h08;
  localparam bit [6:0] B_RIGHT = 7'h04;
  localparam bit [6:0] B_FLAG  = 7'h02;
  localparam bit [6:0] B_STEP  = 7'h01;

  localparam int M_IDLE  = 0;
  localparam int M_PLACE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_WON   = 3;
  localparam int M_LOST  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic        btn_right = 1'b0, btn_flag = 1'b0, btn_step = 1'b0;
  logic [63:0] mineMap, flagMap, stepMap, posMap;
  logic        busy, game_won, game_lost;

  always #5 clk = ~clk;

  board_state #(
    .NUM_MINES   (NM),
    .SEED_DEFAULT(16'hACE1)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .seed     (seed),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_flag (btn_flag),
    .btn_step (btn_step),
    .mineMap  (mineMap),
    .flagMap  (flagMap),
    .stepMap  (stepMap),
    .posMap   (posMap),
    .busy     (busy),
    .game_won (game_won),
    .game_lost(game_lost)
  );

  int checks = 0;
  int failures = 0;

  // Game model
  bit [63:0] m_mine = '0, m_flag = '0, m_step = '0;
  int        m_row = 0, m_col = 0, m_mode = M_IDLE;
  bit [15:0] m_seed = '0;
  bit [6:0]  prev = '0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit [15:0] lfsr_next(input bit [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // First NM distinct non-zero 6-bit values drawn from the LFSR sequence
  function automatic bit [63:0] expected_mines(input bit [15:0] sd);
    bit [15:0] s;
    bit [63:0] m;
    bit [5:0]  c;
    int        n;
    s = (sd == 16'h0) ? 16'hACE1 : sd;
    m = '0;
    n = 0;
    while (n < NM) begin
      c = s[5:0];
      if (c != 6'd0 && !m[c]) begin
        m[c] = 1'b1;
        n++;
      end
      s = lfsr_next(s);
    end
    return m;
  endfunction

  task automatic model_update(input bit [6:0] rise);
    bit [63:0] old_done;
    int        t;
    if (rise[6] && m_mode != M_PLACE) begin
      m_mode = M_PLACE;
      m_mine = '0; m_flag = '0; m_step = '0;
      m_row = 0; m_col = 0;
      m_seed = seed;
      return;
    end
    if (m_mode != M_PLAY) return;
    old_done = m_step | m_mine;
    t = m_row * 8 + m_col;
    if (rise[0]) begin
      if (!m_flag[t] && !m_step[t]) begin
        m_step[t] = 1'b1;
        if (m_mine[t]) begin
          m_step = m_step | m_mine;
          m_mode = M_LOST;
        end
      end
    end else if (rise[1]) begin
      if (!m_step[t]) m_flag[t] = ~m_flag[t];
    end else if (rise[5]) begin
      if (m_row > 0) m_row--;
    end else if (rise[4]) begin
      if (m_row < 7) m_row++;
    end else if (rise[3]) begin
      if (m_col > 0) m_col--;
    end else if (rise[2]) begin
      if (m_col < 7) m_col++;
    end
    if (m_mode == M_PLAY && old_done == '1) m_mode = M_WON;
  endtask

  task automatic set_btns(input bit [6:0] v);
    start     = v[6];
    btn_up    = v[5];
    btn_down  = v[4];
    btn_left  = v[3];
    btn_right = v[2];
    btn_flag  = v[1];
    btn_step  = v[0];
  endtask

  task automatic tick();
    bit [6:0] now_b, rise;
    now_b = {start, btn_up, btn_down, btn_left, btn_right, btn_flag, btn_step};
    rise  = resetn ? (now_b & ~prev) : 7'h0;
    prev  = resetn ? now_b : 7'h0;
    @(posedge clk);
    if (resetn) model_update(rise);
    #1;
  endtask

  task automatic press(input bit [6:0] v);
    set_btns(v);
    tick();
    set_btns(7'h0);
    tick();
  endtask

  task automatic model_reset();
    m_mine = '0; m_flag = '0; m_step = '0;
    m_row = 0; m_col = 0; m_mode = M_IDLE;
  endtask

  task automatic wait_placed();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL place_timeout actual=busy required=done");
    end
    m_mine = expected_mines(m_seed);
    m_mode = M_PLAY;
  endtask

  task automatic start_game(input bit [15:0] s);
    seed = s;
    set_btns(B_START);
    tick();
    set_btns(7'h0);
    wait_placed();
  endtask

  task automatic goto(input int r, input int c);
    while (m_row > r) press(B_UP);
    while (m_row < r) press(B_DOWN);
    while (m_col > c) press(B_LEFT);
    while (m_col < c) press(B_RIGHT);
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_mode == M_PLACE) begin
      check64("place_flagMap", flagMap, 64'h0);
      check64("place_stepMap", stepMap, 64'h0);
      check64("place_posMap", posMap, 64'h1);
      check64("place_busy", 64'(busy), 64'h1);
    end else begin
      check64("cyc_mineMap", mineMap, m_mine);
      check64("cyc_flagMap", flagMap, m_flag);
      check64("cyc_stepMap", stepMap, m_step);
      check64("cyc_posMap", posMap, 64'h1 << (m_row * 8 + m_col));
      check64("cyc_busy", 64'(busy), 64'h0);
      check64("cyc_game_won", 64'(game_won), 64'(m_mode == M_WON));
      check64("cyc_game_lost", 64'(game_lost), 64'(m_mode == M_LOST));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [63:0] cap_a, pos_lost;
    bit [15:0] pin_s;
    int        remaining, t;

    set_btns(7'h0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check64("reset_posMap", posMap, 64'h1);
    check64("reset_mineMap", mineMap, 64'h0);
    check64("reset_busy", 64'(busy), 64'h0);
    resetn = 1'b1;
    tick();

    // Model pins
    pin_s = 16'hACE1;
    check64("pin_lfsr_step", 64'(lfsr_next(pin_s)), 64'h59C3);

    // Game with seed 1234
    start_game(16'h1234);
    check64("g1_mine_count", 64'($countones(mineMap)), 64'd10);
    check64("g1_tile0_safe", 64'(mineMap[0]), 64'h0);

    // Reset in the middle of placement
    seed = 16'h1234;
    set_btns(B_START);
    tick();
    set_btns(7'h0);
    tick();
    check64("midplace_busy", 64'(busy), 64'h1);
    resetn = 1'b0;
    model_reset();
    tick();
    check64("midplace_rst_posMap", posMap, 64'h1);
    check64("midplace_rst_mineMap", mineMap, 64'h0);
    check64("midplace_rst_busy", 64'(busy), 64'h0);
    resetn = 1'b1;
    tick();

    // Seed 0 falls back to the default seed
    start_game(16'h0000);
    cap_a = mineMap;

    // Cursor saturation
    press(B_UP);
    press(B_LEFT);
    check64("cur_corner", posMap, 64'h1);
    repeat (9) press(B_RIGHT);
    check64("cur_right_edge", posMap, 64'h80);
    repeat (9) press(B_DOWN);
    check64("cur_bottom_edge", posMap, 64'h8000_0000_0000_0000);
    goto(0, 0);

    // Flag/step interaction on safe tile 0
    press(B_FLAG);
    check64("flag_set", flagMap, 64'h1);
    press(B_STEP);
    check64("step_on_flag", stepMap, 64'h0);
    press(B_FLAG);
    check64("flag_clear", flagMap, 64'h0);
    press(B_STEP);
    check64("step_reveal", stepMap, 64'h1);
    press(B_FLAG);
    check64("flag_on_revealed", flagMap, 64'h0);

    // Step and right in the same cycle: only the step is taken
    press(B_STEP | B_RIGHT);
    check64("prio_posMap", posMap, 64'h1);

    // Walk the board serpentine and step every safe tile
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (r % 2 == 0) ? k : 7 - k;
        t = r * 8 + c;
        if (!m_mine[t] && !m_step[t]) begin
          goto(r, c);
          remaining = 64 - $countones(m_step | m_mine);
          if (remaining == 1) begin
            set_btns(B_STEP);
            tick();
            check64("win_not_yet", 64'(game_won), 64'h0);
            set_btns(7'h0);
            tick();
            check64("win_next_cycle", 64'(game_won), 64'h1);
          end else begin
            press(B_STEP);
          end
        end
      end
    end
    press(B_LEFT);
    press(B_FLAG);
    check64("won_hold", 64'(game_won), 64'h1);

    // Same mines for seed ACE1; then lose on the first mine
    start_game(16'hACE1);
    check64("seed0_equiv", mineMap, cap_a);
    t = 0;
    while (t < 63 && !m_mine[t]) t++;
    goto(t / 8, t % 8);
    press(B_STEP);
    check64("lost_flag", 64'(game_lost), 64'h1);
    check64("lost_reveal", stepMap & mineMap, mineMap);
    pos_lost = posMap;
    press(B_RIGHT);
    press(B_FLAG);
    press(B_STEP);
    check64("lost_pos_hold", posMap, pos_lost);
    check64("lost_hold", 64'(game_lost), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
